block_result_accumulator: RTL and testbench
===========================================

// Module: block_result_accumulator
// PURPOSE
//  Downstream of the 4x4 block-multiply core. Sums K_BLOCKS partial 4x4 product tiles
//  (A_ik*B_kj, k=0..K_BLOCKS-1) into one output block C_ij.
//  Saturates the sums to Q8.8 and drains the result one row per handshake to the
//  writeback stage. Turns the core's single-tile product into true blocked matrix multiply.
// PARAMETERS
//  DATA_W    16  element width, signed Q8.8 (0x0100 = 1.0)
//  N         4   tile dimension (rows = cols = N); logic is written for N=4
//  K_BLOCKS  4   partial tiles summed per output block (>=1)
//  ACC_W     localparam = DATA_W + clog2(K_BLOCKS) + 1; internal sums never wrap
// PORTS
//  clock       in   1          rising-edge clock
//  reset       in   1          asynchronous, active-high
//  tile_valid  in   1          tile_in holds a partial product tile
//  tile_in     in   N*N*DATA_W element (r,c) at bits [(N*r+c)*DATA_W +: DATA_W], signed
//  tile_ready  out  1          block can accept a tile this cycle
//  out_valid   out  1          out_row holds a finished result row
//  out_ready   in   1          consumer takes out_row this cycle
//  out_row     out  N*DATA_W   saturated row; element c at [c*DATA_W +: DATA_W]
//  out_row_idx out  2          row index 0..N-1 of out_row
//  out_last    out  1          out_valid && out_row_idx==N-1
//  out_sat     out  1          at least one element of current out_row was clamped
//  busy        out  1          state != IDLE
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, k_cnt=0, row_cnt=0, all accumulators=0.
//   Outputs: tile_ready=1, out_valid=0, out_row=0, out_row_idx=0, out_last=0, out_sat=0, busy=0.
//  States:
//   IDLE  - tile_ready=1. On accept: load tile into acc, without adding. k_cnt=1.
//           Next state is DRAIN if K_BLOCKS==1, else ACCUM.
//   ACCUM - tile_ready=1. On accept: acc[r][c] += sign-extended tile element, k_cnt++.
//           The accept that brings k_cnt to K_BLOCKS moves to DRAIN next cycle.
//           No accept: hold state and acc.
//   DRAIN - tile_ready=0; tiles are neither accepted nor lost (the producer holds them).
//           out_valid=1; out_row = sat(acc[row_cnt][*]).
//           Handshake (out_valid&&out_ready) advances row_cnt.
//           Handshake with row_cnt==N-1 -> IDLE, row_cnt=0, k_cnt=0.
//  Accept = tile_valid && tile_ready. Accumulate latency: 1 cycle, sum registered on the accepting edge.
//  First result row is valid on the cycle after the final tile is accepted.
//  Drain takes N cycles minimum with out_ready held high.
//  Backpressure: while out_valid && !out_ready, out_row, out_row_idx, out_last and out_sat hold stable.
//  Saturation: sat(x) = 0x7FFF if x>32767; 0x8000 if x<-32768; else x[DATA_W-1:0].
//   out_sat = OR of the per-element clamp flags of the displayed row (combinational from acc).
//  Simultaneous events: an accept on the DRAIN->IDLE edge cannot occur (tile_ready=0 there).
//   A new block starts on the first accept in IDLE. That tile is a load, so no residue from the previous block remains.
//  tile_valid held with no accept: no effect. out_ready while !out_valid: ignored.
//  Arithmetic is purely integer addition on Q8.8; no rounding or shifting.
// TESTING
//  1 K=4: four tiles, every element 0x0100 -> four rows of {4{0x0400}}, idx 0..3.
//    out_last only on row 3; out_sat=0; busy drops after the last handshake.
//  2 Saturation: four tiles of 0x6000 -> every row 4x0x7FFF, out_sat=1.
//    Four tiles of 0xA000 -> 4x0x8000, out_sat=1.
//    Mixed tiles 0x6000,0xA000,0x6000,0xA000 -> 0x0000, out_sat=0.
//  3 Backpressure: drop out_ready for 3 cycles while idx=1 -> out_row and idx stay stable.
//    No rows are skipped or duplicated; total handshakes = 4.
//  4 tile_valid held through DRAIN -> tile_ready=0, no accept.
//    The tile is accepted as the first of the next block, as a load.
//    A following 3 tiles of 0x0100 plus that tile's value produce the correct fresh sum.
//  5 Assert reset after 2 tiles are accepted -> all outputs return to reset values immediately.
//    A new 4-tile run of 0x0100 yields 0x0400, not 0x0600.
//  6 K_BLOCKS=1 build: one tile holding the product of the 4x4 row/col test matrices -> same values drained.
//    tile_ready is low on the cycle after the accept.

Source files
------------

// File: rtl/block_result_accumulator.sv
// Sums K_BLOCKS partial 4x4 product tiles into one output block,
// then drains it one saturated Q8.8 row per handshake.
module block_result_accumulator #(
  parameter int DATA_W   = 16,
  parameter int N        = 4,
  parameter int K_BLOCKS = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  tile_valid,
  input  logic [N*N*DATA_W-1:0] tile_in,
  output logic                  tile_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N*DATA_W-1:0]   out_row,
  output logic [1:0]            out_row_idx,
  output logic                  out_last,
  output logic                  out_sat,
  output logic                  busy
);

  localparam int ACC_W = DATA_W + $clog2(K_BLOCKS) + 1;
  localparam int KW    = $clog2(K_BLOCKS + 1);

  localparam logic signed [ACC_W-1:0] MAXV =
    ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] MINV = ~MAXV;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t                  state;
  logic [KW-1:0]           k_cnt;
  logic [1:0]              row_cnt;
  logic signed [ACC_W-1:0] acc [N][N];

  logic accept;
  logic hs;

  assign tile_ready  = (state != DRAIN);
  assign out_valid   = (state == DRAIN);
  assign busy        = (state != IDLE);
  assign accept      = tile_valid && tile_ready;
  assign hs          = out_valid && out_ready;
  assign out_row_idx = row_cnt;
  assign out_last    = out_valid && (row_cnt == 2'(N - 1));

  function automatic logic signed [ACC_W-1:0] ext(
    input logic [DATA_W-1:0] v
  );
    return {{(ACC_W - DATA_W){v[DATA_W-1]}}, v};
  endfunction

  // {clamp flag, saturated element}
  function automatic logic [DATA_W:0] sat(
    input logic signed [ACC_W-1:0] x
  );
    if (x > MAXV)
      return {1'b1, MAXV[DATA_W-1:0]};
    else if (x < MINV)
      return {1'b1, MINV[DATA_W-1:0]};
    else
      return {1'b0, x[DATA_W-1:0]};
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      k_cnt   <= '0;
      row_cnt <= '0;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          acc[r][c] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // first tile of a block loads, clearing prior residue
            for (int r = 0; r < N; r++)
              for (int c = 0; c < N; c++)
                acc[r][c] <= ext(tile_in[(N*r+c)*DATA_W +: DATA_W]);
            k_cnt <= KW'(1);
            state <= (K_BLOCKS == 1) ? DRAIN : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            for (int r = 0; r < N; r++)
              for (int c = 0; c < N; c++)
                acc[r][c] <= acc[r][c] +
                  ext(tile_in[(N*r+c)*DATA_W +: DATA_W]);
            k_cnt <= k_cnt + KW'(1);
            if (k_cnt == KW'(K_BLOCKS - 1))
              state <= DRAIN;
          end
        end
        DRAIN: begin
          if (hs) begin
            if (row_cnt == 2'(N - 1)) begin
              state   <= IDLE;
              row_cnt <= '0;
              k_cnt   <= '0;
            end else begin
              row_cnt <= row_cnt + 2'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    logic [DATA_W:0] s;
    out_row = '0;
    out_sat = 1'b0;
    s       = '0;
    if (out_valid) begin
      for (int c = 0; c < N; c++) begin
        s = sat(acc[row_cnt][c]);
        out_row[c*DATA_W +: DATA_W] = s[DATA_W-1:0];
        out_sat = out_sat | s[DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_block_result_accumulator.sv
// Directed bench for block_result_accumulator: K=4 instance
// plus a K_BLOCKS=1 instance.
module tb_block_result_accumulator;

  logic         clk = 1'b0;
  logic         reset;
  logic         tile_valid, tile_ready;
  logic [255:0] tile_in;
  logic         out_valid, out_ready;
  logic [63:0]  out_row;
  logic [1:0]   out_row_idx;
  logic         out_last, out_sat, busy;

  logic         tile_valid1, tile_ready1;
  logic [255:0] tile_in1;
  logic         out_valid1, out_ready1;
  logic [63:0]  out_row1;
  logic [1:0]   out_row_idx1;
  logic         out_last1, out_sat1, busy1;

  int checks = 0;
  int failures = 0;
  int hs = 0;

  always #5 clk = ~clk;

  block_result_accumulator #(.DATA_W(16), .N(4), .K_BLOCKS(4)) dut (
    .clock(clk), .reset(reset),
    .tile_valid(tile_valid), .tile_in(tile_in), .tile_ready(tile_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_row_idx(out_row_idx), .out_last(out_last), .out_sat(out_sat),
    .busy(busy)
  );

  block_result_accumulator #(.DATA_W(16), .N(4), .K_BLOCKS(1)) dut1 (
    .clock(clk), .reset(reset),
    .tile_valid(tile_valid1), .tile_in(tile_in1), .tile_ready(tile_ready1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_row(out_row1),
    .out_row_idx(out_row_idx1), .out_last(out_last1), .out_sat(out_sat1),
    .busy(busy1)
  );

  always @(posedge clk)
    if (out_valid && out_ready) hs <= hs + 1;

  typedef struct packed {
    logic [63:0] t;
    logic [15:0] exp;
    logic        sat;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] uni(input logic [15:0] v);
    return {16{v}};
  endfunction

  task automatic send(input logic [255:0] t);
    int n = 0;
    tile_valid = 1'b1;
    tile_in    = t;
    while (!tile_ready && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) check("send_timeout", 64'd0, 64'd1);
    tick();
    tile_valid = 1'b0;
  endtask

  task automatic drain(input logic [255:0] rows, input logic [3:0] sats,
                       input string nm, input logic chk_tr, input int start);
    out_ready = 1'b1;
    for (int r = start; r < 4; r++) begin
      int n = 0;
      while (!out_valid && n < 20) begin
        tick();
        n++;
      end
      check({nm, "_valid"}, 64'(out_valid), 64'd1);
      check({nm, "_row"}, out_row, rows[r*64 +: 64]);
      check({nm, "_idx"}, 64'(out_row_idx), 64'(r));
      check({nm, "_last"}, 64'(out_last), 64'(r == 3));
      check({nm, "_sat"}, 64'(out_sat), 64'(sats[r]));
      if (chk_tr) check({nm, "_tready"}, 64'(tile_ready), 64'd0);
      tick();
    end
    out_ready = 1'b0;
    check({nm, "_busy_end"}, 64'(busy), 64'd0);
  endtask

  initial begin
    vec_t vecs[8];
    logic [255:0] t;
    logic [255:0] rows;
    logic [63:0] held;
    int hs0;
    int cm [4][4];

    vecs[0] = '{t: {4{16'h0100}}, exp: 16'h0400, sat: 1'b0};
    vecs[1] = '{t: {4{16'h6000}}, exp: 16'h7FFF, sat: 1'b1};
    vecs[2] = '{t: {4{16'hA000}}, exp: 16'h8000, sat: 1'b1};
    vecs[3] = '{t: {16'hA000, 16'h6000, 16'hA000, 16'h6000},
                exp: 16'h0000, sat: 1'b0};
    vecs[4] = '{t: {4{16'hFF00}}, exp: 16'hFC00, sat: 1'b0};
    vecs[5] = '{t: {16'h1FFF, {3{16'h2000}}}, exp: 16'h7FFF, sat: 1'b0};
    vecs[6] = '{t: {4{16'h2000}}, exp: 16'h7FFF, sat: 1'b1};
    vecs[7] = '{t: {4{16'hE000}}, exp: 16'h8000, sat: 1'b0};

    reset = 1'b1;
    tile_valid = 1'b0; tile_in = '0; out_ready = 1'b0;
    tile_valid1 = 1'b0; tile_in1 = '0; out_ready1 = 1'b0;
    tick(); tick();
    check("rst_tready", 64'(tile_ready), 64'd1);
    check("rst_ovalid", 64'(out_valid), 64'd0);
    check("rst_row", out_row, 64'd0);
    check("rst_idx", 64'(out_row_idx), 64'd0);
    check("rst_last", 64'(out_last), 64'd0);
    check("rst_sat", 64'(out_sat), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    tick();

    for (int v = 0; v < 8; v++) begin
      for (int k = 0; k < 4; k++) send(uni(vecs[v].t[k*16 +: 16]));
      check($sformatf("vec%0d_busy", v), 64'(busy), 64'd1);
      drain({16{vecs[v].exp}}, {4{vecs[v].sat}},
            $sformatf("vec%0d", v), 1'b0, 0);
    end

    // backpressure: distinct row values expose skips or duplicates
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[(4*r+c)*16 +: 16] = 16'((r + 1) * 16'h0040);
    for (int r = 0; r < 4; r++)
      rows[r*64 +: 64] = {4{16'((r + 1) * 16'h0100)}};
    hs0 = hs;
    for (int k = 0; k < 4; k++) send(t);
    out_ready = 1'b1;
    check("bp_row0", out_row, rows[63:0]);
    tick();
    out_ready = 1'b0;
    held = out_row;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_row", out_row, held);
      check("bp_hold_idx", 64'(out_row_idx), 64'd1);
    end
    drain(rows, 4'b0, "bp", 1'b0, 1);
    check("bp_handshakes", 64'(hs - hs0), 64'd4);

    // tile held through drain becomes a load of the next block
    for (int k = 0; k < 4; k++) send(uni(16'h0100));
    tile_valid = 1'b1;
    tile_in = uni(16'h0200);
    drain({16{16'h0400}}, 4'b0, "hold", 1'b1, 0);
    tick();
    tile_valid = 1'b0;
    check("hold_loaded_busy", 64'(busy), 64'd1);
    for (int k = 0; k < 3; k++) send(uni(16'h0100));
    drain({16{16'h0500}}, 4'b0, "hold_next", 1'b0, 0);

    // asynchronous reset mid-block
    send(uni(16'h0100));
    send(uni(16'h0100));
    check("mid_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_tready", 64'(tile_ready), 64'd1);
    check("mid_rst_ovalid", 64'(out_valid), 64'd0);
    check("mid_rst_row", out_row, 64'd0);
    tick();
    reset = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) send(uni(16'h0100));
    drain({16{16'h0400}}, 4'b0, "post_rst", 1'b0, 0);

    // K_BLOCKS=1: drain a product of small row/col matrices
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        cm[r][c] = 0;
        for (int k = 0; k < 4; k++)
          cm[r][c] += (r + k + 1) * (k * c + 1);
        tile_in1[(4*r+c)*16 +: 16] = 16'(cm[r][c]);
      end
    tile_valid1 = 1'b1;
    check("k1_tready_pre", 64'(tile_ready1), 64'd1);
    tick();
    tile_valid1 = 1'b0;
    check("k1_tready_after", 64'(tile_ready1), 64'd0);
    out_ready1 = 1'b1;
    for (int r = 0; r < 4; r++) begin
      logic [63:0] er;
      for (int c = 0; c < 4; c++) er[c*16 +: 16] = 16'(cm[r][c]);
      check("k1_valid", 64'(out_valid1), 64'd1);
      check("k1_row", out_row1, er);
      check("k1_idx", 64'(out_row_idx1), 64'(r));
      check("k1_last", 64'(out_last1), 64'(r == 3));
      check("k1_sat", 64'(out_sat1), 64'd0);
      tick();
    end
    out_ready1 = 1'b0;
    check("k1_busy_end", 64'(busy1), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
